// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: instruction, PC, link address, payload, valid and Tnew.
// Define PIPE_PERF_EN to build the stall/bubble performance counters; otherwise they read as 0.
module pipe_stage_reg #(
  parameter int          DATA_W           = 64,
  parameter int          TNEW_W           = 2,
  parameter logic [31:0] RESET_PC         = 32'h0000_3000,
  parameter bit          KEEP_PC_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              valid_i,
  input  logic [31:0]       ins_i,
  input  logic [31:0]       pc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TNEW_W-1:0] tnew_i,
  output logic              valid_o,
  output logic [31:0]       ins_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       pc8_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TNEW_W-1:0] tnew_o,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
);

  localparam logic [TNEW_W-1:0] TNEW_ONE = TNEW_W'(1);

  logic [TNEW_W-1:0] tnew_next;
  logic [31:0]       bubble_pc;

  // Tnew saturates at zero so a finished producer never wraps back to "busy".
  always_comb begin
    tnew_next = '0;
    if (tnew_i != '0)
      tnew_next = tnew_i - TNEW_ONE;
  end

  always_comb begin
    bubble_pc = 32'h0;
    if (KEEP_PC_ON_FLUSH)
      bubble_pc = pc_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_o <= 1'b0;
      ins_o   <= 32'h0;
      pc_o    <= RESET_PC;
      pc8_o   <= RESET_PC + 32'd8;
      data_o  <= '0;
      tnew_o  <= '0;
    end else if (flush) begin
      valid_o <= 1'b0;
      ins_o   <= 32'h0;
      pc_o    <= bubble_pc;
      pc8_o   <= bubble_pc + 32'd8;
      data_o  <= '0;
      tnew_o  <= '0;
    end else if (en) begin
      valid_o <= valid_i;
      ins_o   <= ins_i;
      pc_o    <= pc_i;
      pc8_o   <= pc_i + 32'd8;
      data_o  <= data_i;
      tnew_o  <= tnew_next;
    end
  end

`ifdef PIPE_PERF_EN
  // Stalls only count while a real instruction is being held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else begin
      if (!en && !flush && valid_o && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: table of vectors with a scoreboard queue,
// plus async-reset and post-reset capture sequences.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, flush, valid_i;
  logic [31:0] ins_i, pc_i;
  logic [63:0] data_i;
  logic [1:0]  tnew_i;
  logic        valid_o, valid0_o;
  logic [31:0] ins_o, pc_o, pc8_o, ins0_o, pc0_o, pc80_o;
  logic [63:0] data_o, data0_o;
  logic [1:0]  tnew_o, tnew0_o;
  logic [31:0] stall_cnt, bubble_cnt, stall0_cnt, bubble0_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        en, flush, valid;
    logic [31:0] ins, pc;
    logic [63:0] data;
    logic [1:0]  tnew;
    logic        e_valid;
    logic [31:0] e_ins, e_pc, e_pc8;
    logic [63:0] e_data;
    logic [1:0]  e_tnew;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] ins, pc, pc8, pc0, pc80;
    logic [63:0] data;
    logic [1:0]  tnew;
  } exp_t;

  vec_t        vecs[12];
  exp_t        sb[$];
  logic        model_valid;
  logic [31:0] model_pc0, model_pc80;
  logic [31:0] exp_stall, exp_bubble;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
    .ins_i(ins_i), .pc_i(pc_i), .data_i(data_i), .tnew_i(tnew_i),
    .valid_o(valid_o), .ins_o(ins_o), .pc_o(pc_o), .pc8_o(pc8_o),
    .data_o(data_o), .tnew_o(tnew_o), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  // Second instance exercises the zero-PC bubble variant on the same stimulus.
  pipe_stage_reg #(.KEEP_PC_ON_FLUSH(1'b0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_i(valid_i),
    .ins_i(ins_i), .pc_i(pc_i), .data_i(data_i), .tnew_i(tnew_i),
    .valid_o(valid0_o), .ins_o(ins0_o), .pc_o(pc0_o), .pc8_o(pc80_o),
    .data_o(data0_o), .tnew_o(tnew0_o), .stall_cnt(stall0_cnt), .bubble_cnt(bubble0_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    model_valid = 1'b0;
    model_pc0   = 32'h0000_3000;
    model_pc80  = 32'h0000_3008;
    exp_stall   = 32'h0;
    exp_bubble  = 32'h0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    @(negedge clk);
    en = v.en; flush = v.flush; valid_i = v.valid;
    ins_i = v.ins; pc_i = v.pc; data_i = v.data; tnew_i = v.tnew;
`ifdef PIPE_PERF_EN
    if (v.flush) exp_bubble = exp_bubble + 32'd1;
    else if (!v.en && model_valid) exp_stall = exp_stall + 32'd1;
`endif
    if (v.flush) begin
      model_pc0 = 32'h0; model_pc80 = 32'h8;
    end else if (v.en) begin
      model_pc0 = v.pc; model_pc80 = v.pc + 32'd8;
    end
    model_valid = v.e_valid;
    e.valid = v.e_valid; e.ins = v.e_ins; e.pc = v.e_pc; e.pc8 = v.e_pc8;
    e.data = v.e_data; e.tnew = v.e_tnew; e.pc0 = model_pc0; e.pc80 = model_pc80;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    check("valid_o", {63'd0, valid_o}, {63'd0, e.valid});
    check("ins_o", {32'd0, ins_o}, {32'd0, e.ins});
    check("pc_o", {32'd0, pc_o}, {32'd0, e.pc});
    check("pc8_o", {32'd0, pc8_o}, {32'd0, e.pc8});
    check("data_o", data_o, e.data);
    check("tnew_o", {62'd0, tnew_o}, {62'd0, e.tnew});
    check("pc_o_nokeep", {32'd0, pc0_o}, {32'd0, e.pc0});
    check("pc8_o_nokeep", {32'd0, pc80_o}, {32'd0, e.pc80});
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_valid"}, {63'd0, valid_o}, 64'd0);
    check({tag, "_ins"}, {32'd0, ins_o}, 64'd0);
    check({tag, "_pc"}, {32'd0, pc_o}, 64'h3000);
    check({tag, "_pc8"}, {32'd0, pc8_o}, 64'h3008);
    check({tag, "_data"}, data_o, 64'd0);
    check({tag, "_tnew"}, {62'd0, tnew_o}, 64'd0);
    check({tag, "_stall"}, {32'd0, stall_cnt}, 64'd0);
    check({tag, "_bubble"}, {32'd0, bubble_cnt}, 64'd0);
  endtask

  initial begin
    //           en    fl    vld   ins           pc            data      tnew  | valid ins           pc            pc8           data      tnew
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h8C08_0004, 32'h0000_3004, 64'hA5,   2'd2, 1'b1, 32'h8C08_0004, 32'h0000_3004, 32'h0000_300C, 64'hA5,   2'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_3008, 64'h1234, 2'd0, 1'b1, 32'h0000_0020, 32'h0000_3008, 32'h0000_3010, 64'h1234, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_4000, 64'hDEAD, 2'd3, 1'b1, 32'h0000_0020, 32'h0000_3008, 32'h0000_3010, 64'h1234, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 32'h1111_1111, 32'h0000_5000, 64'hBEEF, 2'd2, 1'b1, 32'h0000_0020, 32'h0000_3008, 32'h0000_3010, 64'h1234, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h2222_2222, 32'h0000_6000, 64'h1,    2'd1, 1'b1, 32'h0000_0020, 32'h0000_3008, 32'h0000_3010, 64'h1234, 2'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'hABCD_EF01, 32'h0000_3010, 64'h77,   2'd3, 1'b0, 32'h0000_0000, 32'h0000_3010, 32'h0000_3018, 64'h0,    2'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFC, 64'h5,    2'd3, 1'b1, 32'h0000_0001, 32'hFFFF_FFFC, 32'h0000_0004, 64'h5,    2'd2};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_3020, 64'h9,    2'd1, 1'b0, 32'h1234_5678, 32'h0000_3020, 32'h0000_3028, 64'h9,    2'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0BAD, 32'h0000_3030, 64'hCC,   2'd2, 1'b0, 32'h0000_0000, 32'h0000_3030, 32'h0000_3038, 64'h0,    2'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0002, 32'h0000_3034, 64'hFEED, 2'd1, 1'b1, 32'h0000_0002, 32'h0000_3034, 32'h0000_303C, 64'hFEED, 2'd0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_3038, 64'h42,   2'd0, 1'b1, 32'h0000_0003, 32'h0000_3038, 32'h0000_3040, 64'h42,   2'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'h0000_3040, 64'h43,   2'd2, 1'b1, 32'h0000_0003, 32'h0000_3038, 32'h0000_3040, 64'h42,   2'd0};

    en = 1'b0; flush = 1'b0; valid_i = 1'b0;
    ins_i = '0; pc_i = '0; data_i = '0; tnew_i = '0;
    reset = 1'b1;
    resetModel();
    #12;
    checkReset("reset");
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end
    check("stall_cnt", {32'd0, stall_cnt}, {32'd0, exp_stall});
    check("bubble_cnt", {32'd0, bubble_cnt}, {32'd0, exp_bubble});

    // Load valid content, then pulse reset between edges and look before the next edge.
    applyStimulus('{1'b1, 1'b0, 1'b1, 32'h0000_00AA, 32'h0000_3100, 64'h55, 2'd3,
                    1'b1, 32'h0000_00AA, 32'h0000_3100, 32'h0000_3108, 64'h55, 2'd2});
    checkOutput();
    #2 reset = 1'b1;
    #1 checkReset("async_reset");
    resetModel();
    #1 reset = 1'b0;
    applyStimulus('{1'b1, 1'b0, 1'b1, 32'h0000_00BB, 32'h0000_3200, 64'h66, 2'd1,
                    1'b1, 32'h0000_00BB, 32'h0000_3200, 32'h0000_3208, 64'h66, 2'd0});
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
